// File: rtl/magic_pkg.sv
// -----------------------------------------------------------------------------
// magic_pkg
//   Shared types and constants for the magic backend retirement logic.
//   - ARCH_REG_W     : architectural register address width (32 registers).
//   - commit_entry_t : per-entry bookkeeping of the commit queue.
//   The result data of each entry lives in a parallel array inside the queue.
//   Its width is a module parameter (DATA_W), and a package typedef cannot
//   follow a module parameter.
// -----------------------------------------------------------------------------
package magic_pkg;

  localparam int ARCH_REG_W = 5;

  typedef struct packed {
    logic                  valid;  // slot holds a dispatched instruction
    logic                  done;   // result has been written back
    logic                  we;     // instruction writes a destination register
    logic [ARCH_REG_W-1:0] addr;   // destination architectural register
  } commit_entry_t;

endpackage

// File: rtl/magic_ring_ptr.sv
// -----------------------------------------------------------------------------
// magic_ring_ptr
//   Head/tail pointer pair for a power-of-two ring buffer. Each pointer carries
//   one extra wrap bit above the index, so equal pointers mean empty and equal
//   indices with different wrap bits mean full.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : return both pointers to zero (wins over increments)
//   inc_tail   : advance tail (an entry was allocated)
//   inc_head   : advance head (an entry retired)
//   head_idx   : head slot index
//   tail_idx   : tail slot index
//   full       : all DEPTH slots occupied
//   empty      : no slot occupied
//   count      : occupied slots, tail_ptr - head_ptr modulo 2^(IDX_W+1)
// -----------------------------------------------------------------------------
module magic_ring_ptr #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inc_tail,
  input  logic             inc_head,
  output logic [IDX_W-1:0] head_idx,
  output logic [IDX_W-1:0] tail_idx,
  output logic             full,
  output logic             empty,
  output logic [IDX_W:0]   count
);

  logic [IDX_W:0] head_ptr;
  logic [IDX_W:0] tail_ptr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (inc_tail) tail_ptr <= tail_ptr + (IDX_W+1)'(1);
      if (inc_head) head_ptr <= head_ptr + (IDX_W+1)'(1);
    end
  end

  assign head_idx = head_ptr[IDX_W-1:0];
  assign tail_idx = tail_ptr[IDX_W-1:0];
  assign empty    = (head_ptr == tail_ptr);
  assign full     = (head_ptr[IDX_W-1:0] == tail_ptr[IDX_W-1:0]) &&
                    (head_ptr[IDX_W]     != tail_ptr[IDX_W]);
  // Wrap-bit arithmetic makes the plain difference the occupancy.
  assign count    = tail_ptr - head_ptr;

endmodule

// File: rtl/magic_commit_queue.sv
// -----------------------------------------------------------------------------
// magic_commit_queue
//   In-order retirement queue. Dispatch allocates a tag at the tail, functional
//   units complete tags out of order, and the head retires in program order by
//   driving the architectural register file write port.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   flush           : discard every entry (redirect / mispredict recovery)
//   alloc_valid     : dispatch requests an entry
//   alloc_ready     : an entry is available (!full)
//   alloc_rd_we     : instruction writes a destination register
//   alloc_rd_addr   : destination architectural register
//   alloc_id        : tag handed out this cycle (tail index)
//   cmpl_valid      : completion strobe
//   cmpl_id         : tag being completed
//   cmpl_data       : result value
//   rd_we           : register file write enable
//   rd_addr         : register file write address
//   rd_wdata        : register file write data
//   commit_valid    : head entry retires this cycle
//   commit_id       : tag retiring (head index)
//   count           : occupied entries
//   empty           : count == 0
// -----------------------------------------------------------------------------
module magic_commit_queue
  import magic_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic                  alloc_rd_we,
  input  logic [ARCH_REG_W-1:0] alloc_rd_addr,
  output logic [IDX_W-1:0]      alloc_id,
  input  logic                  cmpl_valid,
  input  logic [IDX_W-1:0]      cmpl_id,
  input  logic [DATA_W-1:0]     cmpl_data,
  output logic                  rd_we,
  output logic [ARCH_REG_W-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_wdata,
  output logic                  commit_valid,
  output logic [IDX_W-1:0]      commit_id,
  output logic [IDX_W:0]        count,
  output logic                  empty
);

  commit_entry_t       entries [DEPTH];
  logic [DATA_W-1:0]   data_q  [DEPTH];

  logic [IDX_W-1:0]    head_idx;
  logic [IDX_W-1:0]    tail_idx;
  logic                full;
  logic                alloc_fire;
  logic                cmpl_hit;
  commit_entry_t       head_ent;

  // Flush discards a same-cycle allocation; the pointer block also resets on
  // flush, but gating here keeps the entry array from being touched.
  assign alloc_ready = !full;
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign alloc_id    = tail_idx;

  // The entry's valid bit is sampled before the edge, so a completion aimed
  // at the tag being allocated in the same cycle is dropped.
  assign cmpl_hit    = cmpl_valid && entries[cmpl_id].valid;

  magic_ring_ptr #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ring_ptr (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .inc_tail (alloc_fire),
    .inc_head (commit_valid),
    .head_idx (head_idx),
    .tail_idx (tail_idx),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // NOTE: the whole entry array is reset, data included. The queue is small,
  // and a fully defined state after reset keeps stale results from ever
  // reaching the register file port in X-propagating simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
        data_q[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].done  <= 1'b0;
      end
    end else begin
      if (alloc_fire) begin
        entries[tail_idx] <= '{valid: 1'b1, done: 1'b0,
                               we: alloc_rd_we, addr: alloc_rd_addr};
      end
      if (cmpl_hit) begin
        entries[cmpl_id].done <= 1'b1;
        data_q[cmpl_id]       <= cmpl_data;
      end
      // Placed last so a late completion to the retiring head cannot
      // resurrect its done bit.
      if (commit_valid) begin
        entries[head_idx].valid <= 1'b0;
        entries[head_idx].done  <= 1'b0;
      end
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    head_ent     = entries[head_idx];
    commit_valid = head_ent.valid && head_ent.done && !flush;
    rd_we        = 1'b0;
    rd_addr      = '0;
    rd_wdata     = '0;
    if (commit_valid) begin
      // Register 0 is hard-wired, so a write to it retires without a write.
      rd_we    = head_ent.we && (head_ent.addr != '0);
      rd_addr  = head_ent.addr;
      rd_wdata = data_q[head_idx];
    end
  end

  assign commit_id = head_idx;

endmodule
